// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter.
// Define UART_TX_ARB_LOCK_EN to add i_Lock, which pins arbitration to o_Grant.
module uart_tx_arb #(
  parameter int ACTIVE_TIMEOUT = 8
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [3:0]  i_Req_Valid,
  input  logic [31:0] i_Req_Byte,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [3:0]  i_Lock,
`endif
  output logic [3:0]  o_Req_Ready,
  output logic [1:0]  o_Grant,
  output logic        o_Busy,
  output logic        o_Tx_Err,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Active,
  input  logic        i_Tx_Done
);

  localparam int CW = $clog2(ACTIVE_TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(ACTIVE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_WAIT,
    WAIT_DONE,
    DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    elig;
  logic          sel_ok;
  logic [1:0]    sel_idx;
  logic [1:0]    idx;

  // Scan offsets 4..1 so the nearest offset after o_Grant wins.
  always_comb begin
    elig = i_Req_Valid;
`ifdef UART_TX_ARB_LOCK_EN
    if (i_Lock[o_Grant])
      elig = i_Req_Valid & (4'b0001 << o_Grant);
`endif
    sel_ok  = 1'b0;
    sel_idx = o_Grant;
    idx     = o_Grant;
    for (int i = 4; i >= 1; i--) begin
      idx = o_Grant + 2'(i);
      if (elig[idx]) begin
        sel_ok  = 1'b1;
        sel_idx = idx;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      o_Req_Ready <= '0;
      o_Grant     <= 2'd3;
      o_Busy      <= 1'b0;
      o_Tx_Err    <= 1'b0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= '0;
    end else begin
      o_Tx_DV     <= 1'b0;
      o_Req_Ready <= '0;
      o_Tx_Err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!i_Tx_Active && !i_Tx_Done && sel_ok) begin
            o_Tx_Byte   <= i_Req_Byte[8*sel_idx +: 8];
            o_Tx_DV     <= 1'b1;
            o_Req_Ready <= 4'b0001 << sel_idx;
            o_Grant     <= sel_idx;
            o_Busy      <= 1'b1;
            cnt         <= '0;
            state       <= ISSUE_WAIT;
          end
        end
        ISSUE_WAIT: begin
          if (i_Tx_Active) begin
            state <= WAIT_DONE;
          end else if (cnt == LIM) begin
            o_Tx_Err <= 1'b1;
            o_Busy   <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (i_Tx_Done)
            state <= DRAIN;
        end
        DRAIN: begin
          if (!i_Tx_Done) begin
            o_Busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb against a per-requester queue model.
// Exercises the lock feature when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arb;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic [3:0]  i_Req_Valid;
  logic [31:0] i_Req_Byte;
  logic [3:0]  i_Lock;
  logic [3:0]  o_Req_Ready;
  logic [1:0]  o_Grant;
  logic        o_Busy;
  logic        o_Tx_Err;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Active;
  logic        i_Tx_Done;

  int tests_run = 0;
  int failures  = 0;

  logic [7:0] mem [4][32];
  int hd [4];
  int tl [4];
  int mptr;

  always #5 i_Clock = ~i_Clock;

  uart_tx_arb #(.ACTIVE_TIMEOUT(8)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Req_Valid (i_Req_Valid),
    .i_Req_Byte  (i_Req_Byte),
`ifdef UART_TX_ARB_LOCK_EN
    .i_Lock      (i_Lock),
`endif
    .o_Req_Ready (o_Req_Ready),
    .o_Grant     (o_Grant),
    .o_Busy      (o_Busy),
    .o_Tx_Err    (o_Tx_Err),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done)
  );

  task automatic drive_reqs();
    for (int k = 0; k < 4; k++) begin
      i_Req_Valid[k] = (tl[k] > hd[k]);
      if (tl[k] > hd[k])
        i_Req_Byte[8*k +: 8] = mem[k][hd[k]];
      else
        i_Req_Byte[8*k +: 8] = 8'($urandom);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][tl[k]] = b;
    tl[k]++;
  endtask

  // Reference: next pending requester after the last grant, wrapping upward.
  function automatic int exp_pick(input int ptr, input logic [3:0] lock);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (ptr + i) % 4;
      if (!(lock[ptr] && k != ptr) && tl[k] > hd[k])
        return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    i_Reset = 1'b1;
    i_Tx_Active = 1'b0;
    i_Tx_Done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hd[k] = 0;
      tl[k] = 0;
    end
    drive_reqs();
    repeat (2) @(negedge i_Clock);
    i_Reset = 1'b0;
    mptr = 3;
  endtask

  task automatic serve(input int n);
    for (int b = 0; b < n; b++) begin
      int t;
      int k;
      int extra;
      t = 0;
      extra = 0;
      while (!o_Tx_DV && t < 60) begin
        @(negedge i_Clock);
        t++;
      end
      tests_run++;
      if (!o_Tx_DV) begin
        failures++;
        $display("FAIL dv_wait: no o_Tx_DV within %0d clocks, want one", t);
        return;
      end
      if (b > 0) begin
        tests_run++;
        if (t < 2) begin
          failures++;
          $display("FAIL dv_spacing: got %0d clocks after Done fell, want >=2", t);
        end
      end
      k = exp_pick(mptr, i_Lock);
      tests_run++;
      if (k < 0) begin
        failures++;
        $display("FAIL model_pick: got DV with nothing eligible, want none");
        return;
      end
      tests_run++;
      if (o_Req_Ready !== 4'(1 << k)) begin
        failures++;
        $display("FAIL ready: got %b want %b", o_Req_Ready, 4'(1 << k));
      end
      tests_run++;
      if (o_Grant !== 2'(k)) begin
        failures++;
        $display("FAIL grant: got %0d want %0d", o_Grant, k);
      end
      tests_run++;
      if (o_Tx_Byte !== mem[k][hd[k]]) begin
        failures++;
        $display("FAIL tx_byte: got %h want %h", o_Tx_Byte, mem[k][hd[k]]);
      end
      tests_run++;
      if (o_Busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_on: got %b want 1", o_Busy);
      end
      hd[k]++;
      mptr = k;
      drive_reqs();
      repeat ($urandom_range(0, 3)) begin
        @(negedge i_Clock);
        if (o_Tx_DV || o_Req_Ready != 0) extra++;
      end
      i_Tx_Active = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        @(negedge i_Clock);
        if (o_Tx_DV || o_Req_Ready != 0) extra++;
      end
      i_Tx_Done = 1'b1;
      repeat (2) begin
        @(negedge i_Clock);
        if (o_Tx_DV || o_Req_Ready != 0) extra++;
      end
      i_Tx_Done = 1'b0;
      i_Tx_Active = 1'b0;
      tests_run++;
      if (extra !== 0) begin
        failures++;
        $display("FAIL single_dv: got %0d extra DV/ready cycles want 0", extra);
      end
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    @(negedge i_Clock);
    tests_run += 6;
    if (o_Tx_DV !== 1'b0) begin
      failures++; $display("FAIL rst_dv: got %b want 0", o_Tx_DV);
    end
    if (o_Req_Ready !== 4'b0) begin
      failures++; $display("FAIL rst_ready: got %b want 0000", o_Req_Ready);
    end
    if (o_Tx_Err !== 1'b0) begin
      failures++; $display("FAIL rst_err: got %b want 0", o_Tx_Err);
    end
    if (o_Busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy: got %b want 0", o_Busy);
    end
    if (o_Tx_Byte !== 8'h00) begin
      failures++; $display("FAIL rst_byte: got %h want 00", o_Tx_Byte);
    end
    if (o_Grant !== 2'd3) begin
      failures++; $display("FAIL rst_grant: got %0d want 3", o_Grant);
    end
    do_reset();
  endtask

  task automatic test_directed();
    do_reset();
    push(1, 8'h11);
    push(3, 8'h33);
    drive_reqs();
    serve(2);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        push(k, 8'($urandom));
    drive_reqs();
    serve(8);
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      int total;
      total = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = $urandom_range(0, 3);
        for (int j = 0; j < c; j++)
          push(k, 8'($urandom));
        total += c;
      end
      drive_reqs();
      serve(total);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    push(2, 8'h5A);
    drive_reqs();
    n = 0;
    while (!o_Tx_DV && n < 20) begin
      @(negedge i_Clock);
      n++;
    end
    tests_run++;
    if (o_Grant !== 2'd2 || !o_Tx_DV) begin
      failures++;
      $display("FAIL to_grant: got grant %0d dv %b want 2 1", o_Grant, o_Tx_DV);
    end
    hd[2]++;
    mptr = 2;
    drive_reqs();
    n = 0;
    while (!o_Tx_Err && n < 20) begin
      @(negedge i_Clock);
      n++;
    end
    tests_run += 3;
    if (n !== 8) begin
      failures++; $display("FAIL to_delay: got %0d clocks want 8", n);
    end
    if (o_Busy !== 1'b0) begin
      failures++; $display("FAIL to_busy: got %b want 0", o_Busy);
    end
    @(negedge i_Clock);
    if (o_Tx_Err !== 1'b0) begin
      failures++; $display("FAIL to_pulse: got %b want 0", o_Tx_Err);
    end
    push(0, 8'hA0);
    push(3, 8'hA3);
    drive_reqs();
    serve(2);
  endtask

  task automatic test_reset_mid();
    int dvc;
    do_reset();
    push(0, 8'hC0);
    push(1, 8'hC1);
    drive_reqs();
    serve_start();
    @(negedge i_Clock);
    i_Tx_Active = 1'b1;
    repeat (2) @(negedge i_Clock);
    i_Reset = 1'b1;
    @(negedge i_Clock);
    tests_run += 3;
    if (o_Busy !== 1'b0 || o_Tx_DV !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_busy: got busy %b dv %b want 0 0", o_Busy, o_Tx_DV);
    end
    if (o_Grant !== 2'd3 || o_Tx_Byte !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst_regs: got grant %0d byte %h want 3 00", o_Grant, o_Tx_Byte);
    end
    i_Reset = 1'b0;
    mptr = 3;
    dvc = 0;
    repeat (4) begin
      @(negedge i_Clock);
      if (o_Tx_DV) dvc++;
    end
    i_Tx_Done = 1'b1;
    repeat (2) begin
      @(negedge i_Clock);
      if (o_Tx_DV) dvc++;
    end
    i_Tx_Done = 1'b0;
    i_Tx_Active = 1'b0;
    if (dvc !== 0) begin
      failures++; $display("FAIL mid_rst_hold: got %0d DVs want 0", dvc);
    end
    serve(1);
  endtask

  // Take the first grant of a transfer without finishing it.
  task automatic serve_start();
    int t;
    int k;
    t = 0;
    while (!o_Tx_DV && t < 20) begin
      @(negedge i_Clock);
      t++;
    end
    k = exp_pick(mptr, i_Lock);
    tests_run++;
    if (!o_Tx_DV || k < 0 || o_Grant !== 2'(k)) begin
      failures++;
      $display("FAIL start_grant: got dv %b grant %0d want 1 %0d", o_Tx_DV, o_Grant, k);
    end
    if (k >= 0) begin
      hd[k]++;
      mptr = k;
    end
    drive_reqs();
  endtask

`ifdef UART_TX_ARB_LOCK_EN
  task automatic test_lock();
    int dvc;
    do_reset();
    push(2, 8'hE2);
    drive_reqs();
    serve(1);
    i_Lock = 4'b0100;
    for (int j = 0; j < 3; j++)
      push(2, 8'($urandom));
    push(0, 8'hE0);
    drive_reqs();
    serve(3);
    dvc = 0;
    repeat (20) begin
      @(negedge i_Clock);
      if (o_Tx_DV) dvc++;
    end
    tests_run++;
    if (dvc !== 0) begin
      failures++; $display("FAIL lock_hold: got %0d DVs want 0", dvc);
    end
    i_Lock = 4'b0000;
    serve(1);
  endtask
`endif

  initial begin
    i_Reset = 1'b1;
    i_Req_Valid = '0;
    i_Req_Byte = '0;
    i_Lock = '0;
    i_Tx_Active = 1'b0;
    i_Tx_Done = 1'b0;
    test_reset();
    test_directed();
    test_round_robin();
    test_random();
    test_timeout();
    test_reset_mid();
`ifdef UART_TX_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
